regbus_arbiter: RTL

- Shares one single-port 8-bit peripheral register file between two requesters: port 0 is the I2C slave application interface, port 1 is local control logic (dice/display sequencer).
- Performs round-robin arbitration with optional short locked bursts.
- Drives the register-file strobes and routes 1-cycle-latency read data back to the winning requester.
- Sits between the I2C slave / local logic and the shared memory + GPIO/PWM control registers.

---
 rtl/regbus_arbiter_pkg.sv | 26 ++
 rtl/regbus_arbiter_if.sv | 35 +++
 rtl/regbus_arbiter_rr_pick2.sv | 36 +++
 rtl/regbus_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/regbus_arbiter_pkg.sv
// Shared constants for the register-bus arbiter: default widths, register map
// and requester port indices.
package regbus_arbiter_pkg;

    localparam int AW_DEF        = 3;
    localparam int DW_DEF        = 8;
    localparam int MAX_BURST_DEF = 4;
    localparam int BURST_CW      = 4;

    localparam logic [AW_DEF-1:0] MEM0   = 3'd0;
    localparam logic [AW_DEF-1:0] MEM1   = 3'd1;
    localparam logic [AW_DEF-1:0] MEM2   = 3'd2;
    localparam logic [AW_DEF-1:0] MEM3   = 3'd3;
    localparam logic [AW_DEF-1:0] IOCTRL = 3'd4;
    localparam logic [AW_DEF-1:0] IOOE   = 3'd5;
    localparam logic [AW_DEF-1:0] UIO_IN = 3'd6;
    localparam logic [AW_DEF-1:0] UI_IN  = 3'd7;

    localparam logic P_I2C   = 1'b0;
    localparam logic P_LOCAL = 1'b1;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/regbus_arbiter_if.sv
// Bundle of both requester handshakes plus the register-file strobes.
// master = requesters and register file, slave = the arbiter.
interface regbus_arbiter_if #(
    parameter int AW = regbus_arbiter_pkg::AW_DEF,
    parameter int DW = regbus_arbiter_pkg::DW_DEF
);
    logic          req0,   req1;
    logic          lock0,  lock1;
    logic          we0,    we1;
    logic [AW-1:0] addr0,  addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0,   gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/regbus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; the previous owner may keep the
// bus under contention while it locks and its burst count is below the limit.
module rr_pick2 #(
    parameter int MAX_BURST = 4,
    parameter int CW        = 4
) (
    input  logic [1:0]    req_i,
    input  logic [1:0]    lock_i,
    input  logic          last_owner_i,
    input  logic [CW-1:0] burst_cnt_i,
    output logic [1:0]    gnt_o,
    output logic          winner_o,
    output logic          valid_o
);

    localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST - 1);

    logic hold;

    always_comb begin
        hold     = lock_i[last_owner_i] && (burst_cnt_i < BURST_LIM);
        valid_o  = |req_i;
        winner_o = 1'b0;
        case (req_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = hold ? last_owner_i : ~last_owner_i;
            default: winner_o = 1'b0;
        endcase
        gnt_o = 2'b00;
        if (valid_o) begin
            gnt_o[winner_o] = 1'b1;
        end
    end

endmodule

// File: rtl/regbus_arbiter.sv
// Two-requester arbiter for the shared 8-register file: picks a winner each
// cycle, drives the register-file strobes and returns read data one cycle later.
module regbus_arbiter
    import regbus_arbiter_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    regbus_arbiter_if.slave bus
);

    localparam int             CW        = BURST_CW;
    localparam logic [CW-1:0]  BURST_LIM = CW'(MAX_BURST - 1);

    logic [1:0]    pick_gnt;
    logic          pick_valid;
    logic          winner;
    logic          granted;
    logic          we_win;
    logic          lock_win;
    logic          other_req;
    logic [AW-1:0] addr_win;
    logic [DW-1:0] wdata_win;

    logic          last_owner_q, last_owner_d;
    logic [CW-1:0] burst_cnt_q,  burst_cnt_d;
    logic          rd_pending_q, rd_pending_d;
    logic          rd_owner_q,   rd_owner_d;

    rr_pick2 #(
        .MAX_BURST (MAX_BURST),
        .CW        (CW)
    ) u_pick (
        .req_i        ({bus.req1, bus.req0}),
        .lock_i       ({bus.lock1, bus.lock0}),
        .last_owner_i (last_owner_q),
        .burst_cnt_i  (burst_cnt_q),
        .gnt_o        (pick_gnt),
        .winner_o     (winner),
        .valid_o      (pick_valid)
    );

    // Grants are masked while reset is held so no access leaks out of reset.
    assign granted = pick_valid & rst_n;

    always_comb begin
        we_win       = winner ? bus.we1    : bus.we0;
        lock_win     = winner ? bus.lock1  : bus.lock0;
        addr_win     = winner ? bus.addr1  : bus.addr0;
        wdata_win    = winner ? bus.wdata1 : bus.wdata0;
        other_req    = winner ? bus.req0   : bus.req1;

        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        rd_pending_d = 1'b0;
        rd_owner_d   = rd_owner_q;

        if (granted) begin
            last_owner_d = winner;
            // Only contended, locked repeats of the same owner count toward the burst.
            if ((winner == last_owner_q) && other_req && lock_win) begin
                burst_cnt_d = (burst_cnt_q == BURST_LIM) ? burst_cnt_q : burst_cnt_q + CW'(1);
            end else begin
                burst_cnt_d = '0;
            end
            rd_pending_d = ~we_win;
            if (!we_win) begin
                rd_owner_d = winner;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= P_LOCAL;
            burst_cnt_q  <= '0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= P_I2C;
        end else begin
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign bus.gnt0      = pick_gnt[0] & rst_n;
    assign bus.gnt1      = pick_gnt[1] & rst_n;
    assign bus.mem_en    = granted;
    assign bus.mem_we    = granted & we_win;
    assign bus.mem_addr  = granted ? addr_win  : '0;
    assign bus.mem_wdata = granted ? wdata_win : '0;

    // Read data is steered only to the port that issued the read.
    assign bus.rvalid0 = rd_pending_q & (rd_owner_q == P_I2C);
    assign bus.rvalid1 = rd_pending_q & (rd_owner_q == P_LOCAL);
    assign bus.rdata0  = bus.rvalid0 ? bus.mem_rdata : '0;
    assign bus.rdata1  = bus.rvalid1 ? bus.mem_rdata : '0;

endmodule
